// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: ME-stage word request bus plus the external byte-wide memory bus
interface mem_ctrl_if;
    logic        ram_r_enable_i;
    logic        ram_w_enable_i;
    logic [3:0]  ram_w_mask_i;
    logic [31:0] ram_w_data_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_r_data_o;
    logic        ram_busy_o;
    logic        ram_done_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_we_o;
    logic        mem_re_o;
    logic [7:0]  mem_rdata_i;
    modport slave (
        input  ram_r_enable_i, ram_w_enable_i, ram_w_mask_i, ram_w_data_i, ram_addr_i, mem_rdata_i,
        output ram_r_data_o, ram_busy_o, ram_done_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
    );
    modport master (
        output ram_r_enable_i, ram_w_enable_i, ram_w_mask_i, ram_w_data_i, ram_addr_i, mem_rdata_i,
        input  ram_r_data_o, ram_busy_o, ram_done_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: splits 32-bit ME-stage loads/stores into byte transfers on an external memory
module mem_ctrl #(
    parameter int BYTE_LAT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, RD_TAIL, WR, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] base_q, base_d, wdat_q, wdat_d, rdat_q, rdat_d, addr_q, addr_d;
    logic [3:0]  mask_q, mask_d, above;
    logic [7:0]  wb_q, wb_d;
    logic        re_q, re_d, we_q, we_d, busy_q, busy_d, done_q, done_d, req;

    if (BYTE_LAT != 1) begin : g_lat
        $error("mem_ctrl supports BYTE_LAT=1 only");
    end

    function automatic logic [1:0] lowest(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        mask_d  = mask_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        above   = mask_q & (4'b1110 << idx_q);
        req     = bus.ram_r_enable_i || (bus.ram_w_enable_i && |bus.ram_w_mask_i);
        case (state_q)
            RD: begin
                // read data lags the strobe by one cycle, so lane idx-1 lands now
                if (idx_q != 2'd0) rdat_d[{idx_q - 2'd1, 3'b000} +: 8] = bus.mem_rdata_i;
                idx_d   = idx_q + 2'd1;
                state_d = idx_q == 2'd3 ? RD_TAIL : RD;
            end
            RD_TAIL: begin
                rdat_d[31:24] = bus.mem_rdata_i;
                state_d       = DONE;
            end
            WR: begin
                idx_d   = |above ? lowest(above) : idx_q;
                state_d = |above ? WR : DONE;
            end
            default: begin
                idx_d   = 2'd0;
                state_d = IDLE;
                if (req) begin
                    base_d  = bus.ram_addr_i & ~32'd3;
                    mask_d  = bus.ram_w_mask_i;
                    wdat_d  = bus.ram_w_data_i;
                    idx_d   = bus.ram_r_enable_i ? 2'd0 : lowest(bus.ram_w_mask_i);
                    state_d = bus.ram_r_enable_i ? RD : WR;
                end
            end
        endcase
        re_d   = state_d == RD;
        we_d   = state_d == WR;
        addr_d = (re_d || we_d) ? base_d + {30'd0, idx_d} : 32'd0;
        wb_d   = we_d ? wdat_d[{idx_d, 3'b000} +: 8] : 8'd0;
        busy_d = state_d inside {RD, RD_TAIL, WR};
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            base_q  <= 32'd0;
            mask_q  <= 4'd0;
            wdat_q  <= 32'd0;
            rdat_q  <= 32'd0;
            addr_q  <= 32'd0;
            wb_q    <= 8'd0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            addr_q  <= addr_d;
            wb_q    <= wb_d;
            re_q    <= re_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ram_r_data_o = rdat_q;
    assign bus.ram_busy_o   = busy_q;
    assign bus.ram_done_o   = done_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wb_q;
    assign bus.mem_we_o     = we_q;
    assign bus.mem_re_o     = re_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized transactions against a transaction-level model of mem_ctrl
module tb_mem_ctrl;
    typedef struct {
        bit          re, we, busy, done;
        logic [31:0] a;
        logic [7:0]  b;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  ext [256];
    logic [7:0]  mm [256];
    logic [31:0] last_rd = 32'd0;

    mem_ctrl_if bus();
    mem_ctrl #(.BYTE_LAT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // external byte memory: one-cycle read latency, junk on the data bus when not reading
    always @(posedge clk) begin
        if (bus.mem_we_o) ext[bus.mem_addr_o[7:0]] = bus.mem_wdata_o;
        bus.mem_rdata_i <= bus.mem_re_o ? ext[bus.mem_addr_o[7:0]] : 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] m, input logic [31:0] d, input logic [31:0] a);
        bus.ram_r_enable_i = r;
        bus.ram_w_enable_i = w;
        bus.ram_w_mask_i   = m;
        bus.ram_w_data_i   = d;
        bus.ram_addr_i     = a;
    endtask

    task automatic check_cyc(input string tag, input cyc_t c);
        check({tag, ".re"}, 32'(bus.mem_re_o), 32'(c.re));
        check({tag, ".we"}, 32'(bus.mem_we_o), 32'(c.we));
        check({tag, ".busy"}, 32'(bus.ram_busy_o), 32'(c.busy));
        check({tag, ".done"}, 32'(bus.ram_done_o), 32'(c.done));
        check({tag, ".addr"}, bus.mem_addr_o, c.a);
        check({tag, ".wdata"}, 32'(bus.mem_wdata_o), 32'(c.b));
    endtask

    task automatic check_idle(input string tag);
        cyc_t c;
        c = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0};
        check_cyc(tag, c);
    endtask

    // presents one request at the current negedge and follows it through its DONE cycle
    task automatic txn(input string tag, input logic r, input logic w, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] a, input bit noise);
        cyc_t        q[$];
        cyc_t        c;
        logic [31:0] base;
        base = a & ~32'd3;
        drive(r, w, m, d, a);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                c = '{1'b1, 1'b0, 1'b1, 1'b0, base + 32'(i), 8'd0};
                q.push_back(c);
                last_rd[8*i +: 8] = mm[8'(base + 32'(i))];
            end
            c = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 8'd0};
            q.push_back(c);
        end else if (w && m != 4'd0) begin
            for (int l = 0; l < 4; l++) if (m[l]) begin
                c = '{1'b0, 1'b1, 1'b1, 1'b0, base + 32'(l), d[8*l +: 8]};
                q.push_back(c);
                mm[8'(base + 32'(l))] = d[8*l +: 8];
            end
        end
        if (q.size() == 0) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
            check_idle({tag, ".nop"});
        end else begin
            c = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 8'd0};
            q.push_back(c);
        end
        foreach (q[i]) begin
            @(negedge clk);
            if (noise && i < q.size() - 1)
                drive(1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
            else
                drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
            check_cyc($sformatf("%s.c%0d", tag, i + 1), q[i]);
            if (q[i].done) check({tag, ".rdata"}, bus.ram_r_data_o, last_rd);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        cyc_t c;
        logic r, w;
        logic [3:0] m;
        for (int i = 0; i < 256; i++) begin
            ext[i] = 8'($urandom);
            mm[i]  = ext[i];
        end
        ext[0] = 8'h11; ext[1] = 8'h22; ext[2] = 8'h33; ext[3] = 8'h44;
        mm[0]  = 8'h11; mm[1]  = 8'h22; mm[2]  = 8'h33; mm[3]  = 8'h44;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        check_idle("reset");
        check("reset.rdata", bus.ram_r_data_o, 32'd0);
        rst_n = 1'b1;
        txn("lw", 1'b1, 1'b0, 4'd0, 32'd0, 32'h1002, 1'b0);
        check("lw.word", bus.ram_r_data_o, 32'h44332211);
        @(negedge clk);
        check_idle("lw.after");
        txn("sb", 1'b0, 1'b1, 4'b1000, 32'hABABABAB, 32'h2003, 1'b0);
        @(negedge clk);
        check_idle("sb.after");
        txn("sparse", 1'b0, 1'b1, 4'b1001, 32'hDDCCBBAA, 32'h3000, 1'b0);
        @(negedge clk);
        check_idle("sparse.after");
        txn("rw", 1'b1, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h1010, 1'b0);
        txn("b2b", 1'b0, 1'b1, 4'b1111, 32'h01020304, 32'h1010, 1'b0);
        txn("rdback", 1'b1, 1'b0, 4'd0, 32'd0, 32'h1011, 1'b0);
        check("rdback.word", bus.ram_r_data_o, 32'h01020304);
        txn("m0", 1'b0, 1'b1, 4'b0000, 32'h12345678, 32'h1020, 1'b0);
        txn("noise", 1'b1, 1'b0, 4'd0, 32'd0, 32'h1030, 1'b1);
        @(negedge clk);
        check_idle("noise.after");
        drive(1'b1, 1'b0, 4'd0, 32'd0, 32'h1000);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        c = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 8'd0};
        check_cyc("abort.c1", c);
        @(negedge clk);
        c.a = 32'h1001;
        check_cyc("abort.c2", c);
        #2 rst_n = 1'b0;
        #1 check_idle("abort.rst");
        check("abort.rdata", bus.ram_r_data_o, 32'd0);
        last_rd = 32'd0;
        @(negedge clk);
        check_idle("abort.hold");
        rst_n = 1'b1;
        txn("lw2", 1'b1, 1'b0, 4'd0, 32'd0, 32'h1002, 1'b0);
        repeat (60) begin
            r = 1'($urandom);
            w = 1'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            txn("rnd", r, w, m, $urandom, 32'h1000 | 32'($urandom_range(0, 255)), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check_idle("rnd.idle");
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
